// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUND = 2'd2
  } digit_e;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(
    input digit_e d
  );
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    case (d)
      DIG_ONES: oh = 3'b001;
      DIG_TENS: oh = 3'b010;
      DIG_HUND: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD nibble to seven-segment pattern decoder.
// Non-decimal nibbles show a dash.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Map each nibble to its glyph; 10-15 fall through to the dash.
  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Three-digit multiplexed seven-segment scanner with
// leading-zero blanking, per-slot dead time and blinking.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [11:0]   disp;
  logic [SW-1:0] scan_cnt;
  logic          scan_wrap;
  digit_e        index;
  digit_e        index_nxt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          blink_wrap;

  logic [3:0]    nib_hund;
  logic [3:0]    nib_tens;
  logic [3:0]    nib_ones;
  logic [3:0]    nib_sel;
  logic [6:0]    seg_raw;
  logic          blank_dig;
  logic          dark;
  logic [6:0]    seg_nxt;
  logic [2:0]    an_nxt;

  assign nib_hund = disp[11:8];
  assign nib_tens = disp[7:4];
  assign nib_ones = disp[3:0];

  assign scan_wrap  = (scan_cnt == SCAN_LAST);
  assign blink_wrap = (blink_cnt == BLINK_LAST);

  // Display register: captured on load, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp <= '0;
    end else if (load) begin
      disp <= bcd;
    end
  end

  // Free-running slot timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Digit index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= DIG_ONES;
    end else begin
      index <= index_nxt;
    end
  end

  // Advance ones -> tens -> hundreds -> ones on each slot wrap.
  always_comb begin
    index_nxt = index;
    if (scan_wrap) begin
      case (index)
        DIG_ONES: index_nxt = DIG_TENS;
        DIG_TENS: index_nxt = DIG_HUND;
        DIG_HUND: index_nxt = DIG_ONES;
        default:  index_nxt = DIG_ONES;
      endcase
    end
  end

  // Blink timer runs continuously so blink_en only gates output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Select the nibble and the blanking rule for the active digit.
  always_comb begin
    nib_sel   = nib_ones;
    blank_dig = 1'b0;
    case (index)
      DIG_ONES: begin
        nib_sel   = nib_ones;
        blank_dig = 1'b0;
      end
      DIG_TENS: begin
        nib_sel   = nib_tens;
        blank_dig = blank_lz
                  && (nib_hund == 4'd0)
                  && (nib_tens == 4'd0);
      end
      DIG_HUND: begin
        nib_sel   = nib_hund;
        blank_dig = blank_lz
                  && (nib_hund == 4'd0);
      end
      default: begin
        nib_sel   = nib_ones;
        blank_dig = 1'b0;
      end
    endcase
  end

  seg_decoder u_dec (
    .nib (nib_sel),
    .seg (seg_raw)
  );

  assign dark = (scan_cnt == '0)
              || (blink_en && blink_phase);

  // Next output: dark in dead time or blink-off, else the digit.
  always_comb begin
    seg_nxt = SEG_OFF;
    an_nxt  = 3'b000;
    if (!dark) begin
      an_nxt  = digit_onehot(index);
      seg_nxt = blank_dig ? SEG_OFF : seg_raw;
    end
  end

  // Registered drivers for the segment and anode pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= 3'b000;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized self-checking bench for seven_seg_scanner,
// compared against a time-indexed arithmetic reference.
module tb_seven_seg_scanner;

  localparam int SD = 4;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bcd = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg;
  logic [2:0]  an;

  seven_seg_scanner #(
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bcd      (bcd),
    .load     (load),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [6:0]  pat [16];
  int          t;
  logic [11:0] disp_m;

  task automatic chk(input string tag,
                     input logic [9:0] got,
                     input logic [9:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got an/seg=%b/%b expected %b/%b",
                  tag, got[9:7], got[6:0], exp[9:7], exp[6:0]);
  endtask

  // Output after the edge that ends cycle tt (cycles counted from reset).
  function automatic logic [9:0] model(input int tt,
                                       input logic [11:0] d,
                                       input logic bl,
                                       input logic bk);
    int dig;
    int pos;
    logic [3:0] h, te, n;
    logic [6:0] s;
    dig = (tt / SD) % 3;
    pos = tt % SD;
    if (bk && (((tt / BD) % 2) == 1)) return 10'd0;
    if (pos == 0) return 10'd0;
    h  = d[11:8];
    te = d[7:4];
    n  = d[4*dig +: 4];
    s  = pat[n];
    if (bl && dig == 2 && h == 0) s = 7'd0;
    if (bl && dig == 1 && h == 0 && te == 0) s = 7'd0;
    return {3'(1 << dig), s};
  endfunction

  task automatic step(input string tag);
    logic [9:0] e;
    @(posedge clk);
    e = model(t, disp_m, blank_lz, blink_en);
    if (load) disp_m = bcd;
    t++;
    #1 chk(tag, {an, seg}, e);
  endtask

  task automatic show(input logic [11:0] v, input logic bl);
    bcd = v;
    blank_lz = bl;
    load = 1'b1;
    step("load");
    load = 1'b0;
    repeat (12) step("show");
  endtask

  task automatic after_release(input string tag);
    logic [2:0] seq [6];
    seq = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010};
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    disp_m = '0;
    for (int i = 0; i < 6; i++) begin
      step(tag);
      chk({tag, "_an"}, {an, 7'd0}, {seq[i], 7'd0});
    end
  endtask

  initial begin
    pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
            7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
            7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    t = 0;
    disp_m = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset", {an, seg}, 10'd0);
    after_release("release");

    show(12'h123, 1'b0);
    show(12'h007, 1'b1);
    show(12'h007, 1'b0);
    show(12'h000, 1'b1);
    show(12'hA5F, 1'b0);
    show(12'h040, 1'b1);

    blink_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i == 22) begin
        bcd = 12'h986;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step("blink");
    end
    blink_en = 1'b0;
    load = 1'b0;

    for (int i = 0; i < 400; i++) begin
      bcd      = 12'($urandom);
      if ($urandom_range(0, 3) == 0) bcd[11:8] = 4'd0;
      if ($urandom_range(0, 3) == 0) bcd[7:4] = 4'd0;
      load     = ($urandom_range(0, 4) == 0);
      blank_lz = $urandom_range(0, 1) == 1;
      blink_en = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    blink_en = 1'b0;
    blank_lz = 1'b0;
    bcd = 12'h888;
    load = 1'b1;
    step("pre_rst");
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (model(t, disp_m, 1'b0, 1'b0) != 10'd0) break;
      step("pre_rst");
    end
    step("pre_rst");
    #1 rst_n = 1'b0;
    #1 chk("async_rst", {an, seg}, 10'd0);
    @(posedge clk);
    #1 chk("rst_hold", {an, seg}, 10'd0);
    after_release("rerelease");
    repeat (12) step("post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot (minimum 2).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clock cycles per blink half-period (minimum 2).
REQ-003 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port bcd, input, 12: {hundreds, tens, ones} BCD nibbles from the binary-to-BCD stage.
REQ-006 SHALL have port load, input, 1: capture bcd into the display register.
REQ-007 SHALL have port blank_lz, input, 1: enable leading-zero blanking.
REQ-008 SHALL have port blink_en, input, 1: enable whole-display blinking.
REQ-009 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-high.
REQ-010 SHALL have port an, output, 3: digit enables, one-hot active-high; bit0 = ones, bit2 = hundreds.

Function
REQ-011 SHALL latch bcd into a 12-bit display register on a clk edge with load=1; load=0 holds the register.
REQ-012 SHALL run scan_cnt from 0 to SCAN_DIV-1 and wrap to 0, free-running.
REQ-013 SHALL advance digit index 0->1->2->0 on each wrap of scan_cnt, with no other index states reachable.
REQ-014 SHALL register seg and an: the value for the current index and scan_cnt appears one clock later.
REQ-015 SHALL drive an=000 and seg=0 in the cycle following scan_cnt==0 (one-cycle dead time per slot, anti-ghosting); otherwise an=onehot(index).
REQ-016 SHALL decode nibbles 0-9 to standard 7-segment patterns; nibbles 10-15 SHALL display a dash (seg=7'b1000000).
REQ-017 SHALL blank the hundreds digit (seg=0, an still asserted) when blank_lz=1 and the hundreds nibble is 0.
REQ-018 SHALL blank the tens digit when blank_lz=1 and both the hundreds and tens nibbles are 0.
REQ-019 SHALL never blank the ones digit, so value 0 displays "0".
REQ-020 SHALL toggle blink_phase whenever blink_cnt wraps at BLINK_DIV-1; blink_cnt SHALL run regardless of blink_en.
REQ-021 SHALL force an=000 and seg=0 while blink_en=1 and blink_phase=1.
REQ-022 SHALL make a load occurring mid-slot visible on the next registered output, with no slot restart.
REQ-023 SHALL keep scan_cnt and index unaffected by load, blank_lz or blink_en.

Reset
REQ-024 SHALL, while rst_n=0, immediately force display register=0, scan_cnt=0, index=0, blink_cnt=0, blink_phase=0, seg=0, an=000.
REQ-025 SHALL, on rst_n release, start with a dead-time cycle and then show the ones digit (an=001).

Structure
REQ-026 SHALL place NUM_DIGITS=3, the segment encoding constants for 0-9, and the dash constant in the shared package seg_pkg.
REQ-027 SHALL implement the nibble-to-segment decode as the combinational sub-module seg_decoder, instantiated once on the mux output.

Verification (SCAN_DIV=4, BLINK_DIV=16)
REQ-028 SHALL cover: rst_n pulsed low mid-slot -> an=000, seg=0 asynchronously; after release an sequence 000,001,001,001,000,010...
REQ-029 SHALL cover: load bcd=12'h123, blank_lz=0 -> ones slot seg=7'b1001111, tens slot 7'b1011011, hundreds slot 7'b0000110.
REQ-030 SHALL cover: bcd=12'h007, blank_lz=1 -> hundreds and tens slots seg=0, ones slot seg=7'b0000111; with blank_lz=0, hundreds and tens show 7'b0111111.
REQ-031 SHALL cover: bcd=12'h000, blank_lz=1 -> only the ones slot lit, with 7'b0111111.
REQ-032 SHALL cover: bcd=12'hA5F -> hundreds and ones slots show the dash, tens shows 7'b1101101.
REQ-033 SHALL cover: blink_en=1 for 64 cycles -> outputs dark for 16-cycle windows alternating with 16-cycle normal windows; load mid-slot updates seg the next cycle.
